// File: rtl/perceptron_train_seq.sv
// Training sequencer for the perceptron weight table: filters resolved-branch events
// into a FIFO and performs a read-modify-write per event on a read port shared with fetch.
module perceptron_train_seq #(
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 4,
    parameter int THETA  = 4,
    parameter int STARVE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [15:0]      upd_ghr,
    input  logic             upd_dir,
    input  logic             upd_mispred,
    input  logic [8:0]       upd_mag,
    input  logic             pred_rd_req,
    input  logic [IDX_W-1:0] pred_rd_idx,
    output logic             pred_stall,
    output logic             tbl_rd_en,
    output logic [IDX_W-1:0] tbl_rd_idx,
    input  logic [47:0]      tbl_rd_data,
    output logic             tbl_wr_en,
    output logic [IDX_W-1:0] tbl_wr_idx,
    output logic [47:0]      tbl_wr_data,
    output logic [47:0]      dp_weight,
    output logic [15:0]      dp_ghr,
    output logic             dp_dir,
    input  logic [47:0]      dp_weight_new,
    output logic [15:0]      train_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE) + 1;
    localparam int ENT_W = IDX_W + 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t           state_r;
    logic [ENT_W-1:0] fifo_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [SC_W-1:0]  starve_r;
    logic [47:0]      weight_r;
    logic [15:0]      train_cnt_r;

    logic [ENT_W-1:0] head_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             keep_s;
    logic             push_s;
    logic             pop_s;
    logic             at_limit_s;
    logic             claim_s;

    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    // Confident correct predictions are consumed without training.
    assign keep_s     = upd_mispred || (upd_mag <= 9'(THETA));
    assign push_s     = upd_valid && !full_s && keep_s;
    assign pop_s      = (state_r == WR);
    assign head_s     = fifo_r[rd_ptr_r];
    assign head_idx_s = head_s[ENT_W-1:17];
    assign at_limit_s = (starve_r == SC_W'(STARVE - 1));
    assign claim_s    = (state_r == RD) && (!pred_rd_req || at_limit_s);

    assign upd_ready   = !full_s;
    assign dp_weight   = weight_r;
    assign dp_ghr      = head_s[16:1];
    assign dp_dir      = head_s[0];
    assign tbl_wr_en   = (state_r == WR);
    assign tbl_wr_idx  = head_idx_s;
    assign tbl_wr_data = dp_weight_new;
    assign train_cnt   = train_cnt_r;

    // Read-port arbitration: fetch owns the port unless training claims it.
    always_comb begin
        tbl_rd_en  = pred_rd_req;
        tbl_rd_idx = pred_rd_idx;
        pred_stall = 1'b0;
        if (claim_s) begin
            tbl_rd_en  = 1'b1;
            tbl_rd_idx = head_idx_s;
            pred_stall = pred_rd_req;
        end else begin
            tbl_rd_en  = pred_rd_req;
            tbl_rd_idx = pred_rd_idx;
            pred_stall = 1'b0;
        end
    end

    // Event FIFO storage, pointers and occupancy; the head only advances in WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= {upd_idx, upd_ghr, upd_dir};
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Read-modify-write sequencer with starvation counter and captured weight row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            starve_r    <= {SC_W{1'b0}};
            weight_r    <= 48'd0;
            train_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    starve_r <= {SC_W{1'b0}};
                    if (!empty_s) begin
                        state_r <= RD;
                    end
                end
                RD: begin
                    if (claim_s) begin
                        starve_r <= {SC_W{1'b0}};
                        state_r  <= CAP;
                    end else begin
                        starve_r <= starve_r + SC_W'(1);
                    end
                end
                CAP: begin
                    weight_r <= tbl_rd_data;
                    state_r  <= WR;
                end
                WR: begin
                    train_cnt_r <= train_cnt_r + 16'd1;
                    state_r     <= IDLE;
                end
                default: begin
                    starve_r <= {SC_W{1'b0}};
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/perceptron_train_seq.md
# perceptron_train_seq

Training sequencer for the perceptron weight table of the branch predictor. It accepts resolved-branch training events from the EX stage into a small FIFO and decides which ones require training. For each training event it runs a read-modify-write on the 48-bit weight row: read the row, feed it to the combinational weight-update datapath (16 x 3-bit saturating inc/dec), write the result back. The table read port is shared with fetch-stage prediction reads. Prediction has priority, and a starvation guard bounds how long training can be blocked.

## Interface
- IDX_W, default 8: weight-table index width.
- DEPTH, default 4: event FIFO depth (power of 2, at least 2).
- THETA, default 4: training threshold on the perceptron output magnitude.
- STARVE, default 8: consecutive blocked read cycles before training forces the read port.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- upd_valid, in, 1: training event offered by EX.
- upd_ready, out, 1: the FIFO can accept an event; equals !full.
- upd_idx, in, IDX_W: weight row index of the resolved branch.
- upd_ghr, in, 16: global history used for the prediction.
- upd_dir, in, 1: actual branch direction.
- upd_mispred, in, 1: direction or target mispredicted.
- upd_mag, in, 9: unsigned magnitude of the perceptron sum.
- pred_rd_req, in, 1: fetch requests the table read port this cycle.
- pred_rd_idx, in, IDX_W: fetch read index.
- pred_stall, out, 1: the fetch read was denied this cycle.
- tbl_rd_en, out, 1: table read enable.
- tbl_rd_idx, out, IDX_W: table read index.
- tbl_rd_data, in, 48: read data, valid the cycle after tbl_rd_en.
- tbl_wr_en, out, 1: table write enable.
- tbl_wr_idx, out, IDX_W: table write index.
- tbl_wr_data, out, 48: table write data.
- dp_weight, out, 48: captured row driven to the update datapath.
- dp_ghr, out, 16: head-entry history driven to the datapath.
- dp_dir, out, 1: head-entry direction driven to the datapath.
- dp_weight_new, in, 48: combinational datapath result.
- train_cnt, out, 16: count of completed writes; wraps.

## Operation
- **Accept and filter.** An event is accepted when upd_valid && upd_ready.
  - It is pushed only if upd_mispred || (upd_mag <= THETA).
  - Otherwise it is consumed and discarded.
- **FIFO.** Each entry holds {idx, ghr, dir}.
  - Push and pop in the same cycle is allowed.
  - When full, upd_ready=0. There is no bypass, even if a pop occurs that cycle.
- **FSM states: IDLE, RD, CAP, WR.**
- **IDLE.** If the FIFO is non-empty, go to RD.
- **RD.** Claim the read port, then go to CAP.
  - The read port is claimed when !pred_rd_req, or when starve_cnt == STARVE-1.
  - On claim: tbl_rd_en=1, tbl_rd_idx=head.idx.
  - If the port is blocked, stay in RD and increment starve_cnt.
- **Port arbitration.**
  - When training does not claim the port, tbl_rd_en=pred_rd_req and tbl_rd_idx=pred_rd_idx.
  - pred_stall=1 only in a forced-claim cycle in which pred_rd_req=1.
- **CAP.** Register tbl_rd_data into weight_q, then go to WR.
- **WR.**
  - tbl_wr_en=1, tbl_wr_idx=head.idx, tbl_wr_data=dp_weight_new.
  - Pop the FIFO, increment train_cnt, go to IDLE.
- **Datapath drive.** dp_weight=weight_q. dp_ghr and dp_dir come from the FIFO head and are held stable from RD through WR.
- **starve_cnt.** Cleared on every claim and on leaving RD. Width is clog2(STARVE)+1.
- **Back-to-back updates to the same idx.** The next read is issued at least 1 cycle after the previous WR, so it always returns the written row. No forwarding is needed.
- **Reset.**
  - Empties the FIFO, sets the FSM to IDLE, clears starve_cnt and train_cnt.
  - Any in-flight RD/CAP/WR is abandoned with no write.
  - An event offered in the reset cycle is dropped.

## Timing
- Reset values: upd_ready=1; pred_stall=0; tbl_rd_en=pred_rd_req (combinational); tbl_wr_en=0; train_cnt=0; dp_weight=0.
- Minimum latency, with the push at cycle t and no fetch conflict:
  - t+1: IDLE sees the head.
  - t+2: RD issues the read.
  - t+3: CAP captures the row.
  - t+4: WR writes.
- Minimum throughput: one training event per 4 cycles. Worst-case added delay per event: STARVE-1 cycles.
- All outputs except tbl_rd_en, tbl_rd_idx and pred_stall are registered or depend only on FSM state and registered data.

## Test plan
- **Single mispredict, no fetch traffic.** Push idx=0x12, ghr=0xFFFF, dir=1, mispred=1; table row = all 3'b010. Required:
  - Read at t+2.
  - Write at t+4 with row all 3'b011.
  - train_cnt=1.
- **Filter.** mispred=0 with mag=5, then mag=4 (THETA=4). Required: the first event produces no table access; the second is trained.
- **Starvation.** Hold pred_rd_req=1 continuously after a push. Required:
  - The training read is forced on the 8th RD cycle.
  - pred_stall=1 for exactly that cycle.
  - tbl_rd_idx=head.idx in that cycle.
- **Full FIFO.** Push 5 training events back-to-back. Required:
  - upd_ready drops after the 4th push.
  - The 5th is held until the first WR pop.
  - All 5 writes complete in order.
- **Same-idx RAW.** Two events to idx 0x03, both dir=1, ghr=0xFFFF, starting row 3'b001. Required:
  - The second read returns 3'b010.
  - The final write is 3'b011.
- **Reset mid-update.** Assert rst during CAP. Required:
  - No tbl_wr_en.
  - FIFO empty and upd_ready=1 the cycle after reset.
  - train_cnt=0.
